// File: rtl/countdown_timer.sv
// Loadable down-counter with prescaler, start/stop/pause control, optional
// auto-reload and a one-cycle done pulse on terminal count.
module countdown_timer #(
  parameter int BW    = 8,
  parameter int PRESC = 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [BW-1:0] load_val_i,
  input  logic          start_i,
  input  logic          stop_i,
  input  logic          pause_i,
  input  logic          reload_en_i,
  output logic [BW-1:0] count_o,
  output logic          busy_o,
  output logic          done_o
);

  localparam int            PW         = (PRESC > 1) ? $clog2(PRESC) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESC - 1);
  localparam logic [PW-1:0] PRESC_ONE  = PW'(1);
  localparam logic [BW-1:0] COUNT_ONE  = BW'(1);

  typedef enum logic [1:0] {IDLE, RUN, PAUSED} state_t;

  state_t        r_state;
  logic [BW-1:0] r_count;
  logic [BW-1:0] r_reload;
  logic [PW-1:0] r_presc;
  logic          r_busy;
  logic          r_done;

  logic w_tick;
  logic w_loadZero;

  assign w_tick     = (r_presc == PRESC_LAST);
  assign w_loadZero = (load_val_i == '0);

  // Control priority is stop > start > pause; leaving PAUSED takes a
  // counting step in the same cycle so a pause costs exactly its length.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state  <= IDLE;
      r_count  <= '0;
      r_reload <= '0;
      r_presc  <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start_i) begin
            if (w_loadZero) begin
              r_done <= 1'b1;
            end else begin
              r_reload <= load_val_i;
              r_count  <= load_val_i;
              r_presc  <= '0;
              r_state  <= RUN;
              r_busy   <= 1'b1;
            end
          end
        end
        RUN, PAUSED: begin
          if (stop_i) begin
            r_count <= '0;
            r_presc <= '0;
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end else if (start_i) begin
            r_presc <= '0;
            if (w_loadZero) begin
              r_count <= '0;
              r_done  <= 1'b1;
              r_state <= IDLE;
              r_busy  <= 1'b0;
            end else begin
              r_reload <= load_val_i;
              r_count  <= load_val_i;
              r_state  <= RUN;
              r_busy   <= 1'b1;
            end
          end else if (pause_i) begin
            r_state <= PAUSED;
          end else begin
            r_state <= RUN;
            if (w_tick) begin
              r_presc <= '0;
              if (r_count > COUNT_ONE) begin
                r_count <= r_count - COUNT_ONE;
              end else begin
                r_done <= 1'b1;
                if (reload_en_i) begin
                  r_count <= r_reload;
                end else begin
                  r_count <= '0;
                  r_state <= IDLE;
                  r_busy  <= 1'b0;
                end
              end
            end else begin
              r_presc <= r_presc + PRESC_ONE;
            end
          end
        end
        default: begin
          r_state <= IDLE;
          r_count <= '0;
          r_presc <= '0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign count_o = r_count;
  assign busy_o  = r_busy;
  assign done_o  = r_done;

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer: one instance with PRESC=1, one with
// PRESC=4, expected values computed by hand.
module tb_countdown_timer;

  logic       clk;
  logic       rst;
  logic [7:0] loadVal;
  logic       start1, stop1, start4, stop4;
  logic       pause;
  logic       reloadEn;
  logic [7:0] count1, count4;
  logic       busy1, done1, busy4, done4;

  int assertCount = 0;
  int failCount   = 0;

  countdown_timer #(.BW(8), .PRESC(1)) dut1 (
    .clk_i(clk), .rst_i(rst), .load_val_i(loadVal), .start_i(start1),
    .stop_i(stop1), .pause_i(pause), .reload_en_i(reloadEn),
    .count_o(count1), .busy_o(busy1), .done_o(done1)
  );

  countdown_timer #(.BW(8), .PRESC(4)) dut4 (
    .clk_i(clk), .rst_i(rst), .load_val_i(loadVal), .start_i(start4),
    .stop_i(stop4), .pause_i(1'b0), .reload_en_i(reloadEn),
    .count_o(count4), .busy_o(busy4), .done_o(done4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Drive the PRESC=1 instance's controls, then advance one clock edge.
  task automatic applyStimulus(input logic s, input logic [7:0] lv,
                               input logic st, input logic p);
    start1  = s;
    loadVal = lv;
    stop1   = st;
    pause   = p;
    @(posedge clk);
    #1;
  endtask

  task automatic expect1(input string tag, input logic [7:0] c,
                         input logic b, input logic d);
    checkOutput({tag, ".count"}, 32'(count1), 32'(c));
    checkOutput({tag, ".busy"},  32'(busy1),  32'(b));
    checkOutput({tag, ".done"},  32'(done1),  32'(d));
  endtask

  initial begin
    rst = 1'b1; loadVal = '0; start1 = 0; stop1 = 0; start4 = 0; stop4 = 0;
    pause = 0; reloadEn = 0;
    #23;
    expect1("reset", 8'd0, 1'b0, 1'b0);
    checkOutput("reset.count4", 32'(count4), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;

    // Asynchronous reset mid-run, then no done after release
    applyStimulus(1, 8'd10, 0, 0);
    expect1("run10", 8'd10, 1'b1, 1'b0);
    applyStimulus(0, 8'd0, 0, 0);
    expect1("run9", 8'd9, 1'b1, 1'b0);
    #2 rst = 1'b1;
    #1;
    expect1("asyncRst", 8'd0, 1'b0, 1'b0);
    @(negedge clk);
    #2 rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      applyStimulus(0, 8'd0, 0, 0);
      expect1("postRst", 8'd0, 1'b0, 1'b0);
    end

    // PRESC=1, load 3, no reload
    applyStimulus(1, 8'd3, 0, 0);
    expect1("ld3.c3", 8'd3, 1'b1, 1'b0);
    applyStimulus(0, 8'd0, 0, 0);
    expect1("ld3.c2", 8'd2, 1'b1, 1'b0);
    applyStimulus(0, 8'd0, 0, 0);
    expect1("ld3.c1", 8'd1, 1'b1, 1'b0);
    applyStimulus(0, 8'd0, 0, 0);
    expect1("ld3.c0", 8'd0, 1'b0, 1'b1);
    applyStimulus(0, 8'd0, 0, 0);
    expect1("ld3.after", 8'd0, 1'b0, 1'b0);

    // PRESC=4, load 2, auto-reload: done every 8 cycles, count never 0
    reloadEn = 1'b1;
    loadVal  = 8'd2;
    start4   = 1'b1;
    @(posedge clk);
    #1;
    start4 = 1'b0;
    for (int k = 0; k <= 20; k++) begin
      if (k > 0) begin
        @(posedge clk);
        #1;
      end
      checkOutput("rl.count", 32'(count4), (((k / 4) % 2) == 0) ? 32'd2 : 32'd1);
      checkOutput("rl.done",  32'(done4),  (k > 0 && (k % 8) == 0) ? 32'd1 : 32'd0);
      checkOutput("rl.busy",  32'(busy4),  32'd1);
    end
    stop4 = 1'b1;
    @(posedge clk);
    #1;
    stop4 = 1'b0;
    checkOutput("rl.stop.count", 32'(count4), 32'd0);
    checkOutput("rl.stop.busy",  32'(busy4),  32'd0);
    reloadEn = 1'b0;

    // Pause for 3 cycles at count 3 delays done by 3 cycles
    applyStimulus(1, 8'd5, 0, 0);
    expect1("pz.c5", 8'd5, 1'b1, 1'b0);
    applyStimulus(0, 8'd0, 0, 0);
    expect1("pz.c4", 8'd4, 1'b1, 1'b0);
    applyStimulus(0, 8'd0, 0, 0);
    expect1("pz.c3", 8'd3, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 8'd0, 0, 1);
      expect1("pz.hold", 8'd3, 1'b1, 1'b0);
    end
    applyStimulus(0, 8'd0, 0, 0);
    expect1("pz.c2", 8'd2, 1'b1, 1'b0);
    applyStimulus(0, 8'd0, 0, 0);
    expect1("pz.c1", 8'd1, 1'b1, 1'b0);
    applyStimulus(0, 8'd0, 0, 0);
    expect1("pz.c0", 8'd0, 1'b0, 1'b1);

    // Stop wins over start; then a zero load gives a lone done pulse
    applyStimulus(1, 8'd5, 0, 0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 8'd0, 0, 0);
    expect1("st.c2", 8'd2, 1'b1, 1'b0);
    applyStimulus(1, 8'd9, 1, 0);
    expect1("st.stop", 8'd0, 1'b0, 1'b0);
    applyStimulus(0, 8'd0, 0, 0);
    expect1("st.idle", 8'd0, 1'b0, 1'b0);
    applyStimulus(1, 8'd0, 0, 0);
    expect1("st.zero", 8'd0, 1'b0, 1'b1);
    applyStimulus(0, 8'd0, 0, 0);
    expect1("st.zeroEnd", 8'd0, 1'b0, 1'b0);

    // Retrigger at count 2 with 7, then a full-scale 255 countdown
    applyStimulus(1, 8'd4, 0, 0);
    applyStimulus(0, 8'd0, 0, 0);
    applyStimulus(0, 8'd0, 0, 0);
    expect1("rt.c2", 8'd2, 1'b1, 1'b0);
    applyStimulus(1, 8'd7, 0, 0);
    expect1("rt.c7", 8'd7, 1'b1, 1'b0);
    for (int i = 6; i >= 1; i--) begin
      applyStimulus(0, 8'd0, 0, 0);
      expect1("rt.down", 8'(i), 1'b1, 1'b0);
    end
    applyStimulus(0, 8'd0, 0, 0);
    expect1("rt.c0", 8'd0, 1'b0, 1'b1);

    applyStimulus(1, 8'd255, 0, 0);
    expect1("full.c255", 8'd255, 1'b1, 1'b0);
    for (int i = 254; i >= 1; i--) begin
      applyStimulus(0, 8'd0, 0, 0);
      expect1("full.down", 8'(i), 1'b1, 1'b0);
    end
    applyStimulus(0, 8'd0, 0, 0);
    expect1("full.c0", 8'd0, 1'b0, 1'b1);
    applyStimulus(0, 8'd0, 0, 0);
    expect1("full.idle", 8'd0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             assertCount, failCount);
    $finish;
  end

endmodule
